// File: rtl/voice_scheduler.sv
// voice_scheduler: pops one note event per sample tick and allocates it to a voice (retrigger, free or oldest).
module voice_scheduler #(
  parameter int NVOICES = 4,
  parameter int KEYW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_tick,
  input  logic                    fifo_empty,
  input  logic [KEYW-1:0]         fifo_key,
  input  logic [KEYW-1:0]         fifo_vel,
  output logic                    fifo_rd,
  output logic [NVOICES-1:0]      voice_newnote,
  output logic [NVOICES*KEYW-1:0] voice_key,
  output logic [NVOICES-1:0]      voice_active,
  output logic                    busy,
  output logic [KEYW-1:0]         last_key
);
  localparam int IW = $clog2(NVOICES);
  typedef enum logic [1:0] {IDLE, POP, LATCH, APPLY} state_t;
  state_t state;
  logic [KEYW-1:0] key_r, vel_r;
  logic [IW-1:0] rank [NVOICES];
  logic [NVOICES-1:0] match;
  logic [IW-1:0] hit_v, free_v, old_v, sel;
  logic hit, has_free;
  // descending scan so the lowest qualifying index wins
  always_comb begin
    match = '0;
    hit = 1'b0;
    hit_v = '0;
    has_free = 1'b0;
    free_v = '0;
    old_v = '0;
    for (int i = NVOICES - 1; i >= 0; i--) begin
      match[i] = voice_active[i] && voice_key[i*KEYW +: KEYW] == key_r;
      if (match[i]) begin
        hit = 1'b1;
        hit_v = IW'(i);
      end
      if (!voice_active[i]) begin
        has_free = 1'b1;
        free_v = IW'(i);
      end
      if (rank[i] == '0) old_v = IW'(i);
    end
    sel = hit ? hit_v : has_free ? free_v : old_v;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fifo_rd <= 1'b0;
      voice_newnote <= '0;
      voice_key <= '0;
      voice_active <= '0;
      busy <= 1'b0;
      last_key <= '0;
      key_r <= '0;
      vel_r <= '0;
      for (int i = 0; i < NVOICES; i++) rank[i] <= IW'(i);
    end else begin
      fifo_rd <= 1'b0;
      voice_newnote <= '0;
      case (state)
        IDLE: if (sample_tick && !fifo_empty) begin
          state <= POP;
          fifo_rd <= 1'b1;
          busy <= 1'b1;
        end
        POP: state <= LATCH;
        LATCH: begin
          key_r <= fifo_key;
          vel_r <= fifo_vel;
          state <= APPLY;
        end
        APPLY: begin
          state <= IDLE;
          busy <= 1'b0;
          if (vel_r != '0) begin
            voice_key[sel*KEYW +: KEYW] <= key_r;
            voice_active[sel] <= 1'b1;
            voice_newnote[sel] <= 1'b1;
            last_key <= key_r;
            for (int i = 0; i < NVOICES; i++)
              if (rank[i] > rank[sel]) rank[i] <= rank[i] - 1'b1;
            rank[sel] <= IW'(NVOICES - 1);
          end else begin
            voice_active <= voice_active & ~match;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
